// File: rtl/mem_read_arbiter_pkg.sv
// Shared types and constants for the two-port ROM read arbiter.
package arb_pkg;

    localparam int ADDR_W_DEF = 8;
    localparam int DATA_W_DEF = 32;

    localparam logic PORT_DISP = 1'b0;
    localparam logic PORT_AUX  = 1'b1;

    typedef struct packed {
        logic valid;
        logic port;
    } tag_t;

    function automatic logic other_port(input logic port);
        return ~port;
    endfunction

endpackage

// File: rtl/mem_read_arbiter_if.sv
// Requester and memory-side bus of the ROM read arbiter.
interface mem_read_arbiter_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic              req0;
    logic              req1;
    logic [ADDR_W-1:0] addr0;
    logic [ADDR_W-1:0] addr1;
    logic              gnt0;
    logic              gnt1;
    logic              rvalid0;
    logic              rvalid1;
    logic [DATA_W-1:0] rdata0;
    logic [DATA_W-1:0] rdata1;
    logic              mem_en;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_rdata;

    // master: requesters plus the ROM; slave: the arbiter itself
    modport master (
        output req0, req1, addr0, addr1, mem_rdata,
        input  gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_en, mem_addr
    );

    modport slave (
        input  req0, req1, addr0, addr1, mem_rdata,
        output gnt0, gnt1, rvalid0, rvalid1, rdata0, rdata1, mem_en, mem_addr
    );
endinterface

// File: rtl/mem_read_arbiter_lat_tag_pipe.sv
// MEM_LAT-deep shift register of {valid, port} tags matching the ROM read latency.
module lat_tag_pipe
    import arb_pkg::*;
#(
    parameter int MEM_LAT = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  tag_t tag_in,
    output tag_t tag_out
);

    tag_t stage [MEM_LAT];

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < MEM_LAT; i++) begin
                stage[i] <= '0;
            end
        end else begin
            stage[0] <= tag_in;
            for (int i = 1; i < MEM_LAT; i++) begin
                stage[i] <= stage[i-1];
            end
        end
    end

    assign tag_out = stage[MEM_LAT-1];

endmodule

// File: rtl/mem_read_arbiter.sv
// Round-robin arbiter sharing one fixed-latency synchronous ROM between two readers.
module mem_read_arbiter
    import arb_pkg::*;
#(
    parameter int ADDR_W  = ADDR_W_DEF,
    parameter int DATA_W  = DATA_W_DEF,
    parameter int MEM_LAT = 1,
    parameter int CNT_W   = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             hold,
    mem_read_arbiter_if.slave bus,
    output logic [CNT_W-1:0] gcnt0,
    output logic [CNT_W-1:0] gcnt1
);

    logic              rr_ptr;
    logic              grant;
    logic              gnt_port;
    logic [ADDR_W-1:0] issue_addr;
    logic [ADDR_W-1:0] last_addr;
    logic              gnt0_c;
    logic              gnt1_c;
    tag_t              tag_in;
    tag_t              tag_out;

    // Grants are suppressed while reset is asserted so nothing enters the pipe.
    always_comb begin
        grant    = rst_n && !hold && (bus.req0 || bus.req1);
        gnt_port = PORT_DISP;
        if (bus.req0 && bus.req1) begin
            gnt_port = rr_ptr;
        end else if (bus.req1) begin
            gnt_port = PORT_AUX;
        end
    end

    assign gnt0_c     = grant && (gnt_port == PORT_DISP);
    assign gnt1_c     = grant && (gnt_port == PORT_AUX);
    assign issue_addr = (gnt_port == PORT_AUX) ? bus.addr1 : bus.addr0;

    assign bus.gnt0     = gnt0_c;
    assign bus.gnt1     = gnt1_c;
    assign bus.mem_en   = grant;
    assign bus.mem_addr = grant ? issue_addr : last_addr;

    assign tag_in = {grant, gnt_port};

    lat_tag_pipe #(
        .MEM_LAT (MEM_LAT)
    ) u_tag_pipe (
        .clk     (clk),
        .rst_n   (rst_n),
        .tag_in  (tag_in),
        .tag_out (tag_out)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rr_ptr      <= PORT_DISP;
            last_addr   <= '0;
            gcnt0       <= '0;
            gcnt1       <= '0;
            bus.rvalid0 <= 1'b0;
            bus.rvalid1 <= 1'b0;
            bus.rdata0  <= '0;
            bus.rdata1  <= '0;
        end else begin
            if (grant) begin
                rr_ptr    <= other_port(gnt_port);
                last_addr <= issue_addr;
            end
            if (gnt0_c && (gcnt0 != '1)) begin
                gcnt0 <= gcnt0 + 1'b1;
            end
            if (gnt1_c && (gcnt1 != '1)) begin
                gcnt1 <= gcnt1 + 1'b1;
            end
            // Pipe output lines up with mem_rdata for the read issued MEM_LAT cycles ago.
            bus.rvalid0 <= tag_out.valid && (tag_out.port == PORT_DISP);
            bus.rvalid1 <= tag_out.valid && (tag_out.port == PORT_AUX);
            if (tag_out.valid && (tag_out.port == PORT_DISP)) begin
                bus.rdata0 <= bus.mem_rdata;
            end
            if (tag_out.valid && (tag_out.port == PORT_AUX)) begin
                bus.rdata1 <= bus.mem_rdata;
            end
        end
    end

endmodule

// File: tb/tb_mem_read_arbiter.sv
// Bench for mem_read_arbiter: two instances (MEM_LAT=1/CNT_W=4 and MEM_LAT=3/CNT_W=16) share stimulus.
module tb_mem_read_arbiter;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hold = 1'b0;
    logic       req0 = 1'b0;
    logic       req1 = 1'b0;
    logic [7:0] addr0 = '0;
    logic [7:0] addr1 = '0;

    int n_cmp  = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    mem_read_arbiter_if #(.ADDR_W(8), .DATA_W(32)) a_if ();
    mem_read_arbiter_if #(.ADDR_W(8), .DATA_W(32)) b_if ();

    logic [3:0]  a_gc0, a_gc1;
    logic [15:0] b_gc0, b_gc1;

    assign a_if.req0 = req0;  assign a_if.req1 = req1;
    assign a_if.addr0 = addr0; assign a_if.addr1 = addr1;
    assign b_if.req0 = req0;  assign b_if.req1 = req1;
    assign b_if.addr0 = addr0; assign b_if.addr1 = addr1;

    mem_read_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(1), .CNT_W(4)) dut_a (
        .clk(clk), .rst_n(rst_n), .hold(hold), .bus(a_if.slave), .gcnt0(a_gc0), .gcnt1(a_gc1)
    );

    mem_read_arbiter #(.ADDR_W(8), .DATA_W(32), .MEM_LAT(3), .CNT_W(16)) dut_b (
        .clk(clk), .rst_n(rst_n), .hold(hold), .bus(b_if.slave), .gcnt0(b_gc0), .gcnt1(b_gc1)
    );

    function automatic logic [31:0] rom(input logic [7:0] a);
        return {a ^ 8'hA5, a, ~a, a + 8'd1};
    endfunction

    // ROM models: data for the address presented at an edge appears LAT edges later
    logic [31:0] b_pipe [3];
    always @(posedge clk) begin
        a_if.mem_rdata <= rom(a_if.mem_addr);
        b_pipe[0]      <= rom(b_if.mem_addr);
        b_pipe[1]      <= b_pipe[0];
        b_pipe[2]      <= b_pipe[1];
    end
    assign b_if.mem_rdata = b_pipe[2];

    // per-instance views of the outputs
    logic [1:0]  o_gnt [2];
    logic [1:0]  o_rv  [2];
    logic        o_en  [2];
    logic [7:0]  o_addr[2];
    logic [31:0] o_rd0 [2];
    logic [31:0] o_rd1 [2];
    logic [15:0] o_gc0 [2];
    logic [15:0] o_gc1 [2];

    assign o_gnt[0] = {a_if.gnt1, a_if.gnt0};       assign o_gnt[1] = {b_if.gnt1, b_if.gnt0};
    assign o_rv[0]  = {a_if.rvalid1, a_if.rvalid0}; assign o_rv[1]  = {b_if.rvalid1, b_if.rvalid0};
    assign o_en[0]  = a_if.mem_en;                  assign o_en[1]  = b_if.mem_en;
    assign o_addr[0] = a_if.mem_addr;               assign o_addr[1] = b_if.mem_addr;
    assign o_rd0[0] = a_if.rdata0;                  assign o_rd0[1] = b_if.rdata0;
    assign o_rd1[0] = a_if.rdata1;                  assign o_rd1[1] = b_if.rdata1;
    assign o_gc0[0] = {12'd0, a_gc0};               assign o_gc0[1] = b_gc0;
    assign o_gc1[0] = {12'd0, a_gc1};               assign o_gc1[1] = b_gc1;

    task automatic chk(input string name, input int d, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s dut%0d @%0t: got %h, want %h", name, d, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    typedef struct {
        int         dut;
        int         port;
        logic [7:0] addr;
        int         due;
    } rd_t;

    rd_t         pend[$];
    int          cyc = 0;
    bit          active = 0;
    int          m_rr  [2];
    logic [7:0]  m_last[2];
    int          m_gc  [2][2];
    logic [31:0] m_rd  [2][2];
    logic [1:0]  m_rv;
    bit          m_g;
    int          m_p;
    logic [7:0]  m_a;

    function automatic int lat_of(input int d);
        return (d == 0) ? 1 : 3;
    endfunction

    function automatic int cmax_of(input int d);
        return (d == 0) ? 15 : 65535;
    endfunction

    always @(negedge clk) begin
        for (int d = 0; d < 2; d++) begin
            if (active) begin
                m_rv = 2'b00;
                for (int i = 0; i < pend.size(); i++) begin
                    if (pend[i].dut == d && pend[i].due == cyc) begin
                        m_rv[pend[i].port]      = 1'b1;
                        m_rd[d][pend[i].port]   = rom(pend[i].addr);
                        pend.delete(i);
                        break;
                    end
                end
                m_g = rst_n && !hold && (req0 || req1);
                m_p = (req0 && req1) ? m_rr[d] : (req1 ? 1 : 0);
                m_a = (m_p == 1) ? addr1 : addr0;
                chk("gnt",      d, {30'd0, o_gnt[d]}, m_g ? ((m_p == 1) ? 32'd2 : 32'd1) : 32'd0);
                chk("mem_en",   d, {31'd0, o_en[d]},  {31'd0, m_g});
                chk("mem_addr", d, {24'd0, o_addr[d]}, {24'd0, m_g ? m_a : m_last[d]});
                chk("rvalid",   d, {30'd0, o_rv[d]},  {30'd0, m_rv});
                chk("rdata0",   d, o_rd0[d], m_rd[d][0]);
                chk("rdata1",   d, o_rd1[d], m_rd[d][1]);
                chk("gcnt0",    d, {16'd0, o_gc0[d]}, m_gc[d][0]);
                chk("gcnt1",    d, {16'd0, o_gc1[d]}, m_gc[d][1]);
            end
            if (!rst_n) begin
                m_rr[d] = 0;
                m_last[d] = '0;
                m_gc[d][0] = 0; m_gc[d][1] = 0;
                m_rd[d][0] = '0; m_rd[d][1] = '0;
                for (int i = pend.size() - 1; i >= 0; i--) begin
                    if (pend[i].dut == d) pend.delete(i);
                end
            end else if (active && m_g) begin
                m_rr[d]   = 1 - m_p;
                m_last[d] = m_a;
                if (m_gc[d][m_p] < cmax_of(d)) m_gc[d][m_p] = m_gc[d][m_p] + 1;
                pend.push_back('{dut: d, port: m_p, addr: m_a, due: cyc + lat_of(d) + 1});
            end
        end
        if (!rst_n) active = 1;
        cyc++;
    end

    // ---------------- directed stimulus ----------------
    task automatic step(input logic r, input logic h, input logic q0, input logic [7:0] a0,
                        input logic q1, input logic [7:0] a1);
        @(posedge clk);
        #1;
        rst_n = r; hold = h; req0 = q0; addr0 = a0; req1 = q1; addr1 = a1;
        @(negedge clk);
        #1;
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1, 0, 0, 8'h00, 0, 8'h00);
    endtask

    task automatic do_reset();
        step(0, 0, 0, 8'h00, 0, 8'h00);
    endtask

    initial begin
        do_reset();
        do_reset();

        // single requester, MEM_LAT=1: data two cycles after the grant
        step(1, 0, 1, 8'h10, 0, 8'h00);
        chk("lit_t1_gnt", 0, {30'd0, o_gnt[0]}, 32'd1);
        chk("lit_t1_addr", 0, {24'd0, o_addr[0]}, 32'h10);
        idle(1);
        chk("lit_t1_rv_early", 0, {30'd0, o_rv[0]}, 32'd0);
        idle(1);
        chk("lit_t1_rv", 0, {30'd0, o_rv[0]}, 32'd1);
        chk("lit_t1_rdata", 0, o_rd0[0], 32'hB510EF11);
        idle(4);

        // both requesting from rr_ptr=0: strict alternation
        do_reset();
        for (int i = 0; i < 8; i++) begin
            step(1, 0, 1, 8'h20, 1, 8'h30);
            chk("lit_t2_alt", 1, {30'd0, o_gnt[1]}, (i % 2 == 0) ? 32'd1 : 32'd2);
        end
        idle(1);
        chk("lit_t2_gc0", 0, {16'd0, o_gc0[0]}, 32'd4);
        chk("lit_t2_gc1", 0, {16'd0, o_gc1[0]}, 32'd4);
        idle(5);

        // hold blocks issue; the first grant afterwards follows rr_ptr (0 after the alternation)
        for (int i = 0; i < 5; i++) begin
            step(1, 1, 1, 8'h20, 1, 8'h30);
            chk("lit_t3_hold_en", 0, {31'd0, o_en[0]}, 32'd0);
        end
        step(1, 0, 1, 8'h21, 1, 8'h31);
        chk("lit_t3_first", 0, {30'd0, o_gnt[0]}, 32'd1);
        chk("lit_t3_addr", 1, {24'd0, o_addr[1]}, 32'h21);
        idle(5);

        // reset one cycle after a grant discards the in-flight read
        step(1, 0, 1, 8'h44, 0, 8'h00);
        do_reset();
        for (int i = 0; i < 5; i++) begin
            idle(1);
            chk("lit_t4_no_rv_a", 0, {30'd0, o_rv[0]}, 32'd0);
            chk("lit_t4_no_rv_b", 1, {30'd0, o_rv[1]}, 32'd0);
        end
        chk("lit_t4_rdata0", 0, o_rd0[0], 32'd0);
        chk("lit_t4_gc0", 1, {16'd0, o_gc0[1]}, 32'd0);
        chk("lit_t4_addr", 0, {24'd0, o_addr[0]}, 32'd0);
        step(1, 0, 1, 8'h50, 1, 8'h60);
        chk("lit_t4_rr0", 1, {30'd0, o_gnt[1]}, 32'd1);
        idle(5);

        // MEM_LAT=3 back-to-back on port 1 across the address wrap
        do_reset();
        step(1, 0, 0, 8'h00, 1, 8'hFE);
        chk("lit_t5_gnt", 1, {30'd0, o_gnt[1]}, 32'd2);
        chk("lit_t5_addr", 1, {24'd0, o_addr[1]}, 32'hFE);
        step(1, 0, 0, 8'h00, 1, 8'hFF);
        step(1, 0, 0, 8'h00, 1, 8'h00);
        chk("lit_t5_addr_wrap", 1, {24'd0, o_addr[1]}, 32'h00);
        idle(1);
        chk("lit_t5_rv_early", 1, {30'd0, o_rv[1]}, 32'd0);
        idle(1);
        chk("lit_t5_rv_a", 1, {30'd0, o_rv[1]}, 32'd2);
        chk("lit_t5_rd_a", 1, o_rd1[1], 32'h5BFE01FF);
        idle(1);
        chk("lit_t5_rv_b", 1, {30'd0, o_rv[1]}, 32'd2);
        chk("lit_t5_rd_b", 1, o_rd1[1], 32'h5AFF0000);
        idle(1);
        chk("lit_t5_rv_c", 1, {30'd0, o_rv[1]}, 32'd2);
        chk("lit_t5_rd_c", 1, o_rd1[1], 32'hA500FF01);
        idle(3);

        // 20 grants to port 0: 4-bit counter pins at 4'hF, 16-bit counter reaches 20
        do_reset();
        for (int i = 0; i < 20; i++) begin
            step(1, 0, 1, 8'(i), 0, 8'h00);
        end
        idle(1);
        chk("lit_t6_sat", 0, {16'd0, o_gc0[0]}, 32'h0000000F);
        chk("lit_t6_cnt", 1, {16'd0, o_gc0[1]}, 32'd20);
        idle(5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
